// File: rtl/mips_multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS main control FSM.
// Optional ADDI support is enabled by defining MC_ADDI_EN.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] ALUSRCB_B      = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       ir_write;
    logic [1:0] pc_source;
    logic [1:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       instr_done;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'({$bits(ctrl_t){1'b0}});

endpackage

// File: rtl/mc_output_decode.sv
// Combinational state-to-control-word map for the multi-cycle MIPS control.
// ADDI states decode only when MC_ADDI_EN is defined.
module mc_output_decode
  import mips_ctrl_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  // Moore control word per state; FETCH and MEMWR also depend on the memory handshake
  always_comb begin
    ctrl = CTRL_NONE;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = ALUSRCB_FOUR;
        ctrl.alu_op    = ALUOP_ADD;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = ALUSRCB_IMMSH2;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.iord       = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_B;
        ctrl.alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.reg_dst    = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = ALUSRCB_B;
        ctrl.alu_op        = ALUOP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PCSRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
`ifdef MC_ADDI_EN
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = ALUSRCB_IMM;
        ctrl.alu_op    = ALUOP_ADD;
      end
      S_ADDIWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
`endif
      default: ctrl = CTRL_NONE;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multi-cycle MIPS-32 datapath: state register,
// next-state logic, reset gating and sticky IllegalOp. ADDI via MC_ADDI_EN.
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int USE_MEM_READY = 1,
  parameter int STATE_W       = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUop,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               InstrDone,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  state_t state_r;
  state_t state_next_s;
  logic   illegal_op_r;
  logic   illegal_set_s;
  logic   mem_ready_s;
  ctrl_t  ctrl_s;
  ctrl_t  ctrl_gated_s;

  assign mem_ready_s = (USE_MEM_READY != 0) ? MemReady : 1'b1;

  // Next-state selection; DECODE also flags opcodes with no execution path
  always_comb begin
    state_next_s  = S_FETCH;
    illegal_set_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        if (mem_ready_s) state_next_s = S_DECODE;
        else             state_next_s = S_FETCH;
      end
      S_DECODE: begin
        case (Op)
          OP_LW, OP_SW: state_next_s = S_MEMADR;
          OP_RTYPE:     state_next_s = S_EXEC;
          OP_BEQ:       state_next_s = S_BRANCH;
          OP_J:         state_next_s = S_JUMP;
`ifdef MC_ADDI_EN
          OP_ADDI:      state_next_s = S_ADDIEX;
`endif
          default: begin
            state_next_s  = S_FETCH;
            illegal_set_s = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        if (Op == OP_SW) state_next_s = S_MEMWR;
        else             state_next_s = S_MEMRD;
      end
      S_MEMRD: begin
        if (mem_ready_s) state_next_s = S_MEMWB;
        else             state_next_s = S_MEMRD;
      end
      S_MEMWR: begin
        if (mem_ready_s) state_next_s = S_FETCH;
        else             state_next_s = S_MEMWR;
      end
      S_EXEC:   state_next_s = S_ALUWB;
`ifdef MC_ADDI_EN
      S_ADDIEX: state_next_s = S_ADDIWB;
`endif
      default:  state_next_s = S_FETCH;
    endcase
  end

  // State register and sticky illegal-opcode flag, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= S_FETCH;
      illegal_op_r <= 1'b0;
    end else begin
      state_r      <= state_next_s;
      illegal_op_r <= illegal_op_r | illegal_set_s;
    end
  end

  mc_output_decode u_output_decode (
    .state     (state_r),
    .mem_ready (mem_ready_s),
    .ctrl      (ctrl_s)
  );

  // Reset suppresses every strobe so an aborted instruction cannot write
  always_comb begin
    if (reset) ctrl_gated_s = CTRL_NONE;
    else       ctrl_gated_s = ctrl_s;
  end

  assign PCWrite     = ctrl_gated_s.pc_write;
  assign PCWriteCond = ctrl_gated_s.pc_write_cond;
  assign IorD        = ctrl_gated_s.iord;
  assign MemRead     = ctrl_gated_s.mem_read;
  assign MemWrite    = ctrl_gated_s.mem_write;
  assign MemtoReg    = ctrl_gated_s.mem_to_reg;
  assign IRWrite     = ctrl_gated_s.ir_write;
  assign PCSource    = ctrl_gated_s.pc_source;
  assign ALUop       = ctrl_gated_s.alu_op;
  assign ALUSrcA     = ctrl_gated_s.alu_src_a;
  assign ALUSrcB     = ctrl_gated_s.alu_src_b;
  assign RegWrite    = ctrl_gated_s.reg_write;
  assign RegDst      = ctrl_gated_s.reg_dst;
  assign InstrDone   = ctrl_gated_s.instr_done;
  assign IllegalOp   = illegal_op_r;
  assign State       = STATE_W'(state_r);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed self-checking bench for mips_multicycle_control.
// Expectations for opcode 001000 follow MC_ADDI_EN.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0] PCSource, ALUop, ALUSrcB;
  logic       ALUSrcA, RegWrite, RegDst, InstrDone, IllegalOp;
  logic [3:0] State;
  logic [16:0] obs_ctrl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_multicycle_control dut (
    .clk(clk), .reset(reset), .Op(Op), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUop(ALUop),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .InstrDone(InstrDone), .IllegalOp(IllegalOp),
    .State(State)
  );

  assign obs_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                     PCSource, ALUop, ALUSrcA, ALUSrcB, RegWrite, RegDst, InstrDone};

  function automatic logic [16:0] mk(input logic pcw, input logic pcwc, input logic iord,
                                     input logic mr, input logic mw, input logic m2r,
                                     input logic irw, input logic [1:0] pcs,
                                     input logic [1:0] aop, input logic asa,
                                     input logic [1:0] asb, input logic rw,
                                     input logic rd, input logic dn);
    return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, asa, asb, rw, rd, dn};
  endfunction

  localparam logic [16:0] E_NONE     = 17'd0;
  localparam logic [16:0] E_FETCH    = mk(1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0);
  localparam logic [16:0] E_FETCH_NR = mk(1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b01,1'b0,1'b0,1'b0);
  localparam logic [16:0] E_DECODE   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b11,1'b0,1'b0,1'b0);
  localparam logic [16:0] E_MEMADR   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0);
  localparam logic [16:0] E_MEMRD    = mk(1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0);
  localparam logic [16:0] E_MEMWB    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0,1'b1);
  localparam logic [16:0] E_MEMWR_NR = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b0);
  localparam logic [16:0] E_MEMWR    = mk(1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b0,1'b0,1'b1);
  localparam logic [16:0] E_EXEC     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b1,2'b00,1'b0,1'b0,1'b0);
  localparam logic [16:0] E_ALUWB    = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b1,1'b1);
  localparam logic [16:0] E_BRANCH   = mk(1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b01,1'b1,2'b00,1'b0,1'b0,1'b1);
  localparam logic [16:0] E_JUMP     = mk(1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,1'b0,2'b00,1'b0,1'b0,1'b1);
  localparam logic [16:0] E_ADDIEX   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b1,2'b10,1'b0,1'b0,1'b0);
  localparam logic [16:0] E_ADDIWB   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0,2'b00,1'b1,1'b0,1'b1);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Check state and control word in the current cycle, then advance one clock
  task automatic run(input string tag, input logic [3:0] st, input logic [16:0] ec);
    #1;
    chk({tag, " state"}, 32'(State), 32'(st));
    chk({tag, " ctrl"}, 32'(obs_ctrl), 32'(ec));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    Op       = 6'b000000;
    MemReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", 32'(State), 32'd0);
    chk("reset illegal", 32'(IllegalOp), 32'd0);
    chk("reset ctrl", 32'(obs_ctrl), 32'(E_NONE));
    reset = 1'b0;

    // R-type aborted by reset while in EXEC
    run("rt0 fetch", 4'd0, E_FETCH);
    run("rt0 decode", 4'd1, E_DECODE);
    reset = 1'b1;
    run("rst in exec", 4'd6, E_NONE);
    run("rst hold", 4'd0, E_NONE);
    reset = 1'b0;
    chk("post rst illegal", 32'(IllegalOp), 32'd0);

    // full R-type
    run("rt fetch", 4'd0, E_FETCH);
    run("rt decode", 4'd1, E_DECODE);
    run("rt exec", 4'd6, E_EXEC);
    run("rt aluwb", 4'd7, E_ALUWB);

    // lw with fetch stall and 3 wait cycles in MEMRD
    Op = 6'b100011;
    MemReady = 1'b0;
    run("lw fetch stall", 4'd0, E_FETCH_NR);
    MemReady = 1'b1;
    run("lw fetch", 4'd0, E_FETCH);
    run("lw decode", 4'd1, E_DECODE);
    MemReady = 1'b0;
    run("lw memadr", 4'd2, E_MEMADR);
    run("lw memrd w1", 4'd3, E_MEMRD);
    run("lw memrd w2", 4'd3, E_MEMRD);
    run("lw memrd w3", 4'd3, E_MEMRD);
    MemReady = 1'b1;
    run("lw memrd", 4'd3, E_MEMRD);
    run("lw memwb", 4'd4, E_MEMWB);

    // sw with one wait in MEMWR
    Op = 6'b101011;
    run("sw fetch", 4'd0, E_FETCH);
    run("sw decode", 4'd1, E_DECODE);
    MemReady = 1'b0;
    run("sw memadr", 4'd2, E_MEMADR);
    run("sw memwr wait", 4'd5, E_MEMWR_NR);
    MemReady = 1'b1;
    run("sw memwr", 4'd5, E_MEMWR);

    // beq then j
    Op = 6'b000100;
    run("beq fetch", 4'd0, E_FETCH);
    run("beq decode", 4'd1, E_DECODE);
    run("beq branch", 4'd8, E_BRANCH);
    Op = 6'b000010;
    run("j fetch", 4'd0, E_FETCH);
    run("j decode", 4'd1, E_DECODE);
    run("j jump", 4'd9, E_JUMP);

    // illegal opcode returns to FETCH without InstrDone; flag is sticky
    Op = 6'b111111;
    run("ill fetch", 4'd0, E_FETCH);
    chk("ill before", 32'(IllegalOp), 32'd0);
    run("ill decode", 4'd1, E_DECODE);
    chk("ill set", 32'(IllegalOp), 32'd1);
    Op = 6'b000000;
    run("ill return fetch", 4'd0, E_FETCH);
    run("ill rt decode", 4'd1, E_DECODE);
    run("ill rt exec", 4'd6, E_EXEC);
    run("ill rt aluwb", 4'd7, E_ALUWB);
    chk("ill sticky", 32'(IllegalOp), 32'd1);

    // addi after a fresh reset
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("addi pre illegal", 32'(IllegalOp), 32'd0);
    Op = 6'b001000;
    run("addi fetch", 4'd0, E_FETCH);
    run("addi decode", 4'd1, E_DECODE);
`ifdef MC_ADDI_EN
    run("addi ex", 4'd10, E_ADDIEX);
    run("addi wb", 4'd11, E_ADDIWB);
    chk("addi illegal", 32'(IllegalOp), 32'd0);
`else
    run("addi illegal fetch", 4'd0, E_FETCH);
    chk("addi illegal", 32'(IllegalOp), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
